// File: rtl/cotm32_pkg.sv
// Shared core definitions: machine-timer register map and bus helpers.
package cotm32_pkg;

  localparam int XLEN = 32;

  // Machine-timer word offsets (i_addr[4:2])
  localparam logic [2:0] MTIMER_OFFS_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_OFFS_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_OFFS_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_OFFS_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_OFFS_CTRL        = 3'd4;
  localparam logic [2:0] MTIMER_OFFS_PRESCALE    = 3'd5;

  localparam int MTIMER_CTRL_EN_BIT = 0;

  // Window base used by the top-level address decode
  localparam logic [31:0] MTIMER_BASE_ADDR = 32'h0200_0000;

  // Merge the strobed byte lanes of wd into old
  function automatic logic [31:0] mtimer_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/cotm32_priv_pkg.sv
// Privileged-architecture constants (mip/mie bit positions).
package cotm32_priv_pkg;

  localparam int MIP_MTIP_BIT = 7;

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module mtimer_prescaler #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_prescale,
  input  logic         i_clr,
  output logic         o_tick
);

  logic [W-1:0] cnt;

  assign o_tick = i_en && (cnt == i_prescale);

  // Count up to the reload value, then wrap; held at 0 while disabled or cleared
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                     cnt <= '0;
    else if (!i_en || i_clr || o_tick) cnt <= '0;
    else                            cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled tick, MTIP level.
module mmio_timer
  import cotm32_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          OFFS_WIDTH     = 5,
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sel,
  input  logic                  i_we,
  input  logic [OFFS_WIDTH-1:0] i_addr,
  input  logic [XLEN-1:0]       i_wdata,
  input  logic [XLEN/8-1:0]     i_wstrb,
  output logic [XLEN-1:0]       o_rdata,
  output logic                  o_mtip
);

  logic [63:0]               mtime, mtime_nx;
  logic [63:0]               mtimecmp, cmp_nx;
  logic                      en;
  logic [PRESCALE_WIDTH-1:0] presc;
  logic                      tick, presc_clr, wr;
  logic [2:0]                off;
  logic                      addr_unused;

  assign off         = i_addr[4:2];
  assign addr_unused = ^i_addr[1:0];
  assign wr          = i_sel && i_we;
  // A write with no lanes enabled is a no-op, including for the prescaler clear
  assign presc_clr   = wr && (|i_wstrb) &&
                       (off == MTIMER_OFFS_CTRL || off == MTIMER_OFFS_PRESCALE);

  mtimer_prescaler #(.W(PRESCALE_WIDTH)) u_presc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (en),
    .i_prescale (presc),
    .i_clr      (presc_clr),
    .o_tick     (tick)
  );

  // Next mtime/mtimecmp: a software write to mtime overrides (and drops) the tick
  always_comb begin
    mtime_nx = tick ? mtime + 64'd1 : mtime;
    cmp_nx   = mtimecmp;
    if (wr) begin
      case (off)
        MTIMER_OFFS_MTIME_LO:    mtime_nx = {mtime[63:32], mtimer_merge(mtime[31:0], i_wdata, i_wstrb)};
        MTIMER_OFFS_MTIME_HI:    mtime_nx = {mtimer_merge(mtime[63:32], i_wdata, i_wstrb), mtime[31:0]};
        MTIMER_OFFS_MTIMECMP_LO: cmp_nx   = {mtimecmp[63:32], mtimer_merge(mtimecmp[31:0], i_wdata, i_wstrb)};
        MTIMER_OFFS_MTIMECMP_HI: cmp_nx   = {mtimer_merge(mtimecmp[63:32], i_wdata, i_wstrb), mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  // Timer state and registered MTIP compare against the post-edge values
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
      en       <= 1'b0;
      presc    <= '0;
      o_mtip   <= 1'b0;
    end else begin
      mtime    <= mtime_nx;
      mtimecmp <= cmp_nx;
      o_mtip   <= (mtime_nx >= cmp_nx);
      if (wr && off == MTIMER_OFFS_CTRL && i_wstrb[0])
        en <= i_wdata[MTIMER_CTRL_EN_BIT];
      if (wr && off == MTIMER_OFFS_PRESCALE)
        for (int b = 0; b < PRESCALE_WIDTH/8; b++)
          if (i_wstrb[b]) presc[8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // Zero-wait-state read mux; unmapped words and deselected reads return 0
  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      case (off)
        MTIMER_OFFS_MTIME_LO:    o_rdata = mtime[31:0];
        MTIMER_OFFS_MTIME_HI:    o_rdata = mtime[63:32];
        MTIMER_OFFS_MTIMECMP_LO: o_rdata = mtimecmp[31:0];
        MTIMER_OFFS_MTIMECMP_HI: o_rdata = mtimecmp[63:32];
        MTIMER_OFFS_CTRL:        o_rdata[MTIMER_CTRL_EN_BIT] = en;
        MTIMER_OFFS_PRESCALE:    o_rdata[PRESCALE_WIDTH-1:0] = presc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus random bus traffic.
module tb_mmio_timer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_sel = 1'b0;
  logic        i_we  = 1'b0;
  logic [4:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic [31:0] o_rdata;
  logic        o_mtip;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: architectural registers plus cycles since the prescaler phase restarted
  logic [63:0] m_time, m_cmp;
  logic        m_en;
  logic [15:0] m_ps;
  int unsigned m_k;
  logic        m_mtip;

  mmio_timer dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sel   (i_sel),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_wstrb (i_wstrb),
    .o_rdata (o_rdata),
    .o_mtip  (o_mtip)
  );

  always #50 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] off);
    case (off)
      3'd0: return m_time[31:0];
      3'd1: return m_time[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {31'b0, m_en};
      3'd5: return {16'b0, m_ps};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_time = '0; m_cmp = '1; m_en = 1'b0; m_ps = '0; m_k = 0; m_mtip = 1'b0;
  endtask

  // One clock edge: tick when the enabled phase count lands on the last slot of a PRESCALE+1 period
  task automatic model_edge(input logic we, input logic [2:0] off, input logic [31:0] wd,
                            input logic [3:0] s);
    logic        tick, en_old, clr;
    logic [63:0] t;
    logic [31:0] tmp;
    en_old = m_en;
    tick   = m_en && ((m_k % (int'(m_ps) + 1)) == int'(m_ps));
    t      = tick ? m_time + 64'd1 : m_time;
    clr    = we && (s != 4'h0) && (off == 3'd4 || off == 3'd5);
    if (we) begin
      case (off)
        3'd0: t = {m_time[63:32], lanes(m_time[31:0], wd, s)};
        3'd1: t = {lanes(m_time[63:32], wd, s), m_time[31:0]};
        3'd2: m_cmp[31:0]  = lanes(m_cmp[31:0], wd, s);
        3'd3: m_cmp[63:32] = lanes(m_cmp[63:32], wd, s);
        3'd4: if (s[0]) m_en = wd[0];
        3'd5: begin tmp = lanes({16'h0, m_ps}, wd, s); m_ps = tmp[15:0]; end
        default: ;
      endcase
    end
    m_k    = (clr || !en_old) ? 0 : m_k + 1;
    m_time = t;
    m_mtip = (m_time >= m_cmp);
  endtask

  task automatic step(input logic we, input logic [2:0] off, input logic [31:0] wd,
                      input logic [3:0] s);
    i_sel = we; i_we = we; i_addr = {off, 2'b00}; i_wdata = wd; i_wstrb = s;
    model_edge(we, off, wd, s);
    @(posedge i_clk);
    #1;
    i_sel = 1'b0; i_we = 1'b0; i_wstrb = '0;
    chk("mtip_model", {63'b0, o_mtip}, {63'b0, m_mtip});
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    step(1'b1, off, wd, 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    i_sel = 1'b1; i_we = 1'b0; i_addr = {off, 2'b00};
    #1;
    chk(tag, {32'b0, o_rdata}, {32'b0, exp});
    i_sel = 1'b0;
  endtask

  initial begin
    logic [31:0] rst_exp [8];
    logic [31:0] prev_lo;
    rst_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    model_reset();

    // Reset contents of every offset
    #120;
    i_rst = 1'b1;
    for (int i = 0; i < 8; i++) rd("reset_rd", 3'(i), rst_exp[i]);
    chk("reset_mtip", {63'b0, o_mtip}, 64'h0);

    // PRESCALE=3: one tick every 4th cycle, 4 ticks in 16 cycles, then freeze
    wr(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    prev_lo = 32'h0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      rd("presc3_lo", 3'd0, mread(3'd0));
      i_sel = 1'b1; i_addr = 5'd0; #1;
      chk("presc3_spacing", {63'b0, o_rdata != prev_lo}, {63'b0, (i % 4) == 3});
      prev_lo = o_rdata; i_sel = 1'b0;
    end
    rd("presc3_total", 3'd0, 32'd4);
    wr(3'd4, 32'd0);
    idle(5);
    rd("frozen_lo", 3'd0, 32'd4);

    // LO->HI carry in the same cycle
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd4, 32'd1);
    idle(2);
    rd("carry_hi", 3'd1, 32'd1);
    rd("carry_lo", 3'd0, 32'd0);

    // Write beats tick; partial byte-lane merge
    wr(3'd0, 32'h1234_5678);
    rd("wr_prio_lo", 3'd0, 32'h1234_5678);
    step(1'b1, 3'd0, 32'h0000_0100, 4'b0011);
    rd("merge_lo", 3'd0, 32'h1234_0100);
    rd("merge_hi", 3'd1, 32'd1);

    // MTIP rises on the edge where mtime reaches mtimecmp, clears when cmp raised
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd10);
    wr(3'd4, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      chk("mtip_rise", {63'b0, o_mtip}, {63'b0, i >= 10});
    end
    wr(3'd2, 32'hFFFF_FFFF);
    chk("mtip_clear", {63'b0, o_mtip}, 64'h0);

    // Asynchronous reset mid-count with MTIP high
    wr(3'd2, 32'd0);
    chk("mtip_preset", {63'b0, o_mtip}, 64'h1);
    #20;
    i_rst = 1'b0;
    #1;
    chk("async_mtip", {63'b0, o_mtip}, 64'h0);
    rd("async_lo", 3'd0, 32'h0);
    rd("async_cmp", 3'd2, 32'hFFFF_FFFF);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b1;

    // Random bus traffic against the model
    wr(3'd5, 32'd1);
    wr(3'd4, 32'd1);
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  off;
      logic [31:0] wd;
      logic [3:0]  s;
      off = 3'($urandom_range(0, 7));
      wd  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 24)) : $urandom;
      if (off == 3'd5) wd = 32'($urandom_range(0, 3));
      if (off == 3'd4) wd = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'h1;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6) step(1'b0, 3'd0, 32'h0, 4'h0);
      else                          step(1'b1, off, wd, s);
      off = 3'($urandom_range(0, 7));
      rd("rand_rd", off, mread(off));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
